// File: rtl/sc_psr_ctrl_if.sv
// ALU-completion, PSR-flag and branch-evaluation signals between the ALU/fetch side and the PSR controller.
interface sc_psr_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  SC_PsrCtrl_AluValid_In;
  logic                  SC_PsrCtrl_AluReady_Out;
  logic [5:0]            SC_PsrCtrl_AluOp3_In;
  logic [DATA_WIDTH-1:0] SC_PsrCtrl_AluResult_In;
  logic                  SC_PsrCtrl_AluOverflow_In;
  logic                  SC_PsrCtrl_AluCarry_In;
  logic [3:0]            SC_PsrCtrl_Flags_In;
  logic                  SC_PsrCtrl_Negativo_Out;
  logic                  SC_PsrCtrl_Cero_Out;
  logic                  SC_PsrCtrl_Overflow_Out;
  logic                  SC_PsrCtrl_Carry_Out;
  logic                  SC_PsrCtrl_Write_OutLow;
  logic                  SC_PsrCtrl_BrValid_In;
  logic                  SC_PsrCtrl_BrReady_Out;
  logic [3:0]            SC_PsrCtrl_BrCond_In;
  logic                  SC_PsrCtrl_BrDone_Out;
  logic                  SC_PsrCtrl_BrTaken_Out;

  modport master (
    output SC_PsrCtrl_AluValid_In, SC_PsrCtrl_AluOp3_In, SC_PsrCtrl_AluResult_In,
           SC_PsrCtrl_AluOverflow_In, SC_PsrCtrl_AluCarry_In, SC_PsrCtrl_Flags_In,
           SC_PsrCtrl_BrValid_In, SC_PsrCtrl_BrCond_In,
    input  SC_PsrCtrl_AluReady_Out, SC_PsrCtrl_Negativo_Out, SC_PsrCtrl_Cero_Out,
           SC_PsrCtrl_Overflow_Out, SC_PsrCtrl_Carry_Out, SC_PsrCtrl_Write_OutLow,
           SC_PsrCtrl_BrReady_Out, SC_PsrCtrl_BrDone_Out, SC_PsrCtrl_BrTaken_Out
  );

  modport slave (
    input  SC_PsrCtrl_AluValid_In, SC_PsrCtrl_AluOp3_In, SC_PsrCtrl_AluResult_In,
           SC_PsrCtrl_AluOverflow_In, SC_PsrCtrl_AluCarry_In, SC_PsrCtrl_Flags_In,
           SC_PsrCtrl_BrValid_In, SC_PsrCtrl_BrCond_In,
    output SC_PsrCtrl_AluReady_Out, SC_PsrCtrl_Negativo_Out, SC_PsrCtrl_Cero_Out,
           SC_PsrCtrl_Overflow_Out, SC_PsrCtrl_Carry_Out, SC_PsrCtrl_Write_OutLow,
           SC_PsrCtrl_BrReady_Out, SC_PsrCtrl_BrDone_Out, SC_PsrCtrl_BrTaken_Out
  );
endinterface

// File: rtl/sc_psr_ctrl.sv
// PSR write sequencer and Bicc evaluator: cc op -> WRITE -> SETTLE (3-cycle spacing), branch result 1 cycle after accept.
// Backpressure: ALU ready only in IDLE; branches are held off while a cc op is accepted or its write is in flight.
module sc_psr_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input logic          SC_PsrCtrl_CLOCK_50,
  input logic          SC_PsrCtrl_RESET_InLow,
  sc_psr_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, SETTLE, EVAL} state_t;

  state_t state, state_nxt;
  logic   alu_ready, br_ready, alu_go, br_go;
  logic   cc_op, logic_op, taken_now;
  logic   n_q, z_q, v_q, c_q, taken_q;

  // Flags are {N,Z,V,C}; cond[3] inverts the base condition selected by cond[2:0].
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic r;
    case (cond[2:0])
      3'd0:    r = 1'b0;
      3'd1:    r = f[2];
      3'd2:    r = f[2] | (f[3] ^ f[1]);
      3'd3:    r = f[3] ^ f[1];
      3'd4:    r = f[0] | f[2];
      3'd5:    r = f[0];
      3'd6:    r = f[3];
      default: r = f[1];
    endcase
    return r ^ cond[3];
  endfunction

  always_comb begin
    logic_op = 1'b0;
    case (bus.SC_PsrCtrl_AluOp3_In[3:0])
      4'b0001, 4'b0010, 4'b0011,
      4'b0101, 4'b0110, 4'b0111: logic_op = 1'b1;
      default:                   logic_op = 1'b0;
    endcase
  end

  assign cc_op     = bus.SC_PsrCtrl_AluOp3_In[4];
  assign alu_ready = (state == IDLE);
  assign br_ready  = (state == IDLE) && !(bus.SC_PsrCtrl_AluValid_In && cc_op);
  assign alu_go    = bus.SC_PsrCtrl_AluValid_In && alu_ready;
  assign br_go     = bus.SC_PsrCtrl_BrValid_In && br_ready;
  assign taken_now = cond_eval(bus.SC_PsrCtrl_BrCond_In, bus.SC_PsrCtrl_Flags_In);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (alu_go && cc_op) state_nxt = WRITE;
        else if (br_go)      state_nxt = EVAL;
      end
      WRITE:   state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge SC_PsrCtrl_CLOCK_50 or negedge SC_PsrCtrl_RESET_InLow) begin
    if (!SC_PsrCtrl_RESET_InLow) begin
      state   <= IDLE;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (alu_go && cc_op) begin
        n_q <= bus.SC_PsrCtrl_AluResult_In[DATA_WIDTH-1];
        z_q <= (bus.SC_PsrCtrl_AluResult_In == '0);
        v_q <= logic_op ? 1'b0 : bus.SC_PsrCtrl_AluOverflow_In;
        c_q <= logic_op ? 1'b0 : bus.SC_PsrCtrl_AluCarry_In;
      end
      if (br_go) taken_q <= taken_now;
    end
  end

  // Strobe decodes straight from the async-reset state, so reset deasserts it immediately.
  assign bus.SC_PsrCtrl_Write_OutLow = (state != WRITE);
  assign bus.SC_PsrCtrl_AluReady_Out = alu_ready;
  assign bus.SC_PsrCtrl_BrReady_Out  = br_ready;
  assign bus.SC_PsrCtrl_BrDone_Out   = (state == EVAL);
  assign bus.SC_PsrCtrl_BrTaken_Out  = (state == EVAL) && taken_q;
  assign bus.SC_PsrCtrl_Negativo_Out = n_q;
  assign bus.SC_PsrCtrl_Cero_Out     = z_q;
  assign bus.SC_PsrCtrl_Overflow_Out = v_q;
  assign bus.SC_PsrCtrl_Carry_Out    = c_q;

endmodule

// File: tb/tb_sc_psr_ctrl.sv
// Directed bench for sc_psr_ctrl: reset, cc writes, non-cc ops, cc/branch priority, reset mid-write, Bicc sweep.
module tb_sc_psr_ctrl;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  logic [15:0] exp_tbl;
  logic [3:0]  flags_out;

  sc_psr_ctrl_if #(.DATA_WIDTH(32)) bus ();

  sc_psr_ctrl #(.DATA_WIDTH(32)) dut (
    .SC_PsrCtrl_CLOCK_50   (clk),
    .SC_PsrCtrl_RESET_InLow(rst_n),
    .bus                   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign flags_out = {bus.SC_PsrCtrl_Negativo_Out, bus.SC_PsrCtrl_Cero_Out,
                      bus.SC_PsrCtrl_Overflow_Out, bus.SC_PsrCtrl_Carry_Out};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic alu_drive(input logic [5:0] op3, input logic [31:0] res, input logic ovf, input logic cy);
    bus.SC_PsrCtrl_AluValid_In    = 1'b1;
    bus.SC_PsrCtrl_AluOp3_In      = op3;
    bus.SC_PsrCtrl_AluResult_In   = res;
    bus.SC_PsrCtrl_AluOverflow_In = ovf;
    bus.SC_PsrCtrl_AluCarry_In    = cy;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    bus.SC_PsrCtrl_AluValid_In    = 1'b0;
    bus.SC_PsrCtrl_AluOp3_In      = 6'd0;
    bus.SC_PsrCtrl_AluResult_In   = 32'd0;
    bus.SC_PsrCtrl_AluOverflow_In = 1'b0;
    bus.SC_PsrCtrl_AluCarry_In    = 1'b0;
    bus.SC_PsrCtrl_Flags_In       = 4'b0000;
    bus.SC_PsrCtrl_BrValid_In     = 1'b0;
    bus.SC_PsrCtrl_BrCond_In      = 4'b0000;

    #12;
    chk("rst_write_n", bus.SC_PsrCtrl_Write_OutLow, 1);
    chk("rst_flags",   flags_out, 4'b0000);
    chk("rst_brdone",  bus.SC_PsrCtrl_BrDone_Out, 0);
    chk("rst_brtaken", bus.SC_PsrCtrl_BrTaken_Out, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_aluready", bus.SC_PsrCtrl_AluReady_Out, 1);
    chk("idle_brready",  bus.SC_PsrCtrl_BrReady_Out, 1);
    tick();

    // BE against all flags set
    bus.SC_PsrCtrl_Flags_In   = 4'b1111;
    bus.SC_PsrCtrl_BrValid_In = 1'b1;
    bus.SC_PsrCtrl_BrCond_In  = 4'b0001;
    tick();
    bus.SC_PsrCtrl_BrValid_In = 1'b0;
    chk("be_done",  bus.SC_PsrCtrl_BrDone_Out, 1);
    chk("be_taken", bus.SC_PsrCtrl_BrTaken_Out, 1);
    tick();
    chk("be_done_pulse", bus.SC_PsrCtrl_BrDone_Out, 0);

    // subcc, result 0, carry 1
    alu_drive(6'b010100, 32'd0, 1'b0, 1'b1);
    #1;
    chk("subcc_aluready", bus.SC_PsrCtrl_AluReady_Out, 1);
    chk("subcc_brready",  bus.SC_PsrCtrl_BrReady_Out, 0);
    tick();
    bus.SC_PsrCtrl_AluValid_In = 1'b0;
    chk("subcc_write",   bus.SC_PsrCtrl_Write_OutLow, 0);
    chk("subcc_flags",   flags_out, 4'b0101);
    chk("subcc_rdy_wr",  bus.SC_PsrCtrl_AluReady_Out, 0);
    tick();
    chk("subcc_settle_w",  bus.SC_PsrCtrl_Write_OutLow, 1);
    chk("subcc_settle_rd", bus.SC_PsrCtrl_AluReady_Out, 0);
    tick();
    chk("subcc_idle_rd", bus.SC_PsrCtrl_AluReady_Out, 1);
    chk("subcc_hold",    flags_out, 4'b0101);

    // andcc clears V and C despite ALU overflow/carry
    alu_drive(6'b010001, 32'h8000_0000, 1'b1, 1'b1);
    tick();
    bus.SC_PsrCtrl_AluValid_In = 1'b0;
    chk("andcc_write", bus.SC_PsrCtrl_Write_OutLow, 0);
    chk("andcc_flags", flags_out, 4'b1000);
    tick();
    chk("andcc_settle", bus.SC_PsrCtrl_Write_OutLow, 1);
    tick();
    chk("andcc_once", bus.SC_PsrCtrl_Write_OutLow, 1);

    // non-cc add leaves everything alone
    alu_drive(6'b000000, 32'h0000_1234, 1'b1, 1'b1);
    tick();
    bus.SC_PsrCtrl_AluValid_In = 1'b0;
    chk("add_write", bus.SC_PsrCtrl_Write_OutLow, 1);
    chk("add_ready", bus.SC_PsrCtrl_AluReady_Out, 1);
    chk("add_flags", flags_out, 4'b1000);

    // cc op and BE in the same cycle; branch must see the new (Z=0) flags
    bus.SC_PsrCtrl_Flags_In = 4'b0100;
    alu_drive(6'b010000, 32'd5, 1'b0, 1'b0);
    bus.SC_PsrCtrl_BrValid_In = 1'b1;
    bus.SC_PsrCtrl_BrCond_In  = 4'b0001;
    #1;
    chk("prio_brready_acc", bus.SC_PsrCtrl_BrReady_Out, 0);
    tick();
    bus.SC_PsrCtrl_AluValid_In = 1'b0;
    chk("prio_brready_wr", bus.SC_PsrCtrl_BrReady_Out, 0);
    chk("prio_flags",      flags_out, 4'b0000);
    tick();
    bus.SC_PsrCtrl_Flags_In = 4'b0000;
    chk("prio_brready_st", bus.SC_PsrCtrl_BrReady_Out, 0);
    chk("prio_no_done",    bus.SC_PsrCtrl_BrDone_Out, 0);
    tick();
    chk("prio_brready_idle", bus.SC_PsrCtrl_BrReady_Out, 1);
    tick();
    bus.SC_PsrCtrl_BrValid_In = 1'b0;
    chk("prio_done",  bus.SC_PsrCtrl_BrDone_Out, 1);
    chk("prio_taken", bus.SC_PsrCtrl_BrTaken_Out, 0);
    tick();

    // reset in the middle of WRITE
    alu_drive(6'b010100, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    bus.SC_PsrCtrl_AluValid_In = 1'b0;
    chk("rstwr_low", bus.SC_PsrCtrl_Write_OutLow, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstwr_async", bus.SC_PsrCtrl_Write_OutLow, 1);
    chk("rstwr_flags", flags_out, 4'b0000);
    rst_n = 1'b1;
    tick();
    chk("rstwr_idle_w",  bus.SC_PsrCtrl_Write_OutLow, 1);
    chk("rstwr_idle_rd", bus.SC_PsrCtrl_AluReady_Out, 1);
    chk("rstwr_idle_bd", bus.SC_PsrCtrl_BrDone_Out, 0);

    // Bicc sweep, expected tables indexed by cond
    for (int pass = 0; pass < 2; pass++) begin
      bus.SC_PsrCtrl_Flags_In = (pass == 0) ? 4'b0101 : 4'b1010;
      exp_tbl                 = (pass == 0) ? 16'hC936 : 16'h3FC0;
      for (int c = 0; c < 16; c++) begin
        bus.SC_PsrCtrl_BrValid_In = 1'b1;
        bus.SC_PsrCtrl_BrCond_In  = 4'(c);
        tick();
        bus.SC_PsrCtrl_BrValid_In = 1'b0;
        chk($sformatf("sweep_done_f%0d_c%0d", pass, c), bus.SC_PsrCtrl_BrDone_Out, 1);
        chk($sformatf("sweep_taken_f%0d_c%0d", pass, c), bus.SC_PsrCtrl_BrTaken_Out, 32'(exp_tbl[c]));
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sc_psr_ctrl.md
Name: sc_psr_ctrl

Overview:
Controller that sequences writes into the processor status register (PSR, NZVC flags) and evaluates branch conditions against its output.
- Accepts ALU completions through a valid/ready handshake.
- Derives NZVC for condition-code-setting ops and issues the active-low PSR write strobe.
- Holds off branch evaluation until the PSR output reflects the new flags.
- Sits between the ALU, the PSR and the fetch/branch unit.

Parameters:
- DATA_WIDTH, 32, width of the ALU result bus.

Ports:
- SC_PsrCtrl_CLOCK_50  in  1  system clock, rising edge.
- SC_PsrCtrl_RESET_InLow  in  1  reset, asynchronous, active-low.
- SC_PsrCtrl_AluValid_In  in  1  ALU result valid.
- SC_PsrCtrl_AluReady_Out  out  1  controller can accept an ALU result.
- SC_PsrCtrl_AluOp3_In  in  6  SPARC op3 of the completing instruction.
- SC_PsrCtrl_AluResult_In  in  DATA_WIDTH  ALU result.
- SC_PsrCtrl_AluOverflow_In  in  1  ALU overflow.
- SC_PsrCtrl_AluCarry_In  in  1  ALU carry.
- SC_PsrCtrl_Flags_In  in  4  current PSR output {N,Z,V,C}.
- SC_PsrCtrl_Negativo_Out, SC_PsrCtrl_Cero_Out, SC_PsrCtrl_Overflow_Out, SC_PsrCtrl_Carry_Out  out  1 each  flag values to the PSR.
- SC_PsrCtrl_Write_OutLow  out  1  PSR write strobe, active-low.
- SC_PsrCtrl_BrValid_In  in  1  branch evaluation request.
- SC_PsrCtrl_BrReady_Out  out  1  branch request accepted this cycle.
- SC_PsrCtrl_BrCond_In  in  4  SPARC Bicc cond field.
- SC_PsrCtrl_BrDone_Out  out  1  one-cycle pulse: branch result valid.
- SC_PsrCtrl_BrTaken_Out  out  1  branch outcome, valid while BrDone=1.

Behaviour:
- Reset (async, RESET_InLow=0):
  - state=IDLE; Write_OutLow=1; flag outputs=0; BrDone=0; BrTaken=0.
  - Asserting reset mid-sequence forces Write_OutLow high immediately, so no partial PSR write occurs.
- FSM states: IDLE, WRITE, SETTLE, EVAL.
- Handshake outputs:
  - AluReady=1 only in IDLE.
  - BrReady=1 only in IDLE and not (AluValid & AluOp3[4]).
  - ALU transfer occurs when AluValid & AluReady; branch transfer when BrValid & BrReady.
- IDLE:
  - ALU transfer with AluOp3[4]=0 (non-cc op): consumed, no state change, no write.
  - ALU transfer with AluOp3[4]=1: register flag outputs and go to WRITE.
    - N=Result[DATA_WIDTH-1]; Z=(Result==0).
    - If AluOp3[3:0] ∈ {0001,0010,0011,0101,0110,0111} (logic cc ops): V=0, C=0. Otherwise V=AluOverflow, C=AluCarry.
  - Branch transfer (only possible when no cc ALU transfer): register Cond and go to EVAL.
  - Priority: a cc ALU op beats a branch in the same cycle. The branch stays pending, is accepted after SETTLE, and sees the new flags.
- WRITE: Write_OutLow=0 for exactly one cycle; the PSR captures on the following edge; next state SETTLE.
- SETTLE: Write_OutLow=1; one bubble cycle so Flags_In reflects the new value; next state IDLE.
- EVAL:
  - BrDone=1 and BrTaken=f(Cond, Flags_In sampled on the acceptance edge), both for one cycle; next state IDLE.
  - Latency from branch acceptance to BrDone is 1 cycle.
- Condition function f (Cond: result), SPARC Bicc:
  - 1000: 1; 0000: 0
  - 1001: ~Z; 0001: Z
  - 1010: ~(Z|(N^V)); 0010: Z|(N^V)
  - 1011: ~(N^V); 0011: N^V
  - 1100: ~(C|Z); 0100: C|Z
  - 1101: ~C; 0101: C
  - 1110: ~N; 0110: N
  - 1111: ~V; 0111: V
- Flag outputs hold their last written value outside WRITE.
- The PSR contents are never altered except via the WRITE cycle.
- Back-to-back cc ops: minimum spacing is 3 cycles (accept, WRITE, SETTLE). AluReady=0 enforces this.
- Unused Cond patterns: none; all 16 are defined.

Test Plan:
- Reset then release:
  - Write_OutLow=1, AluReady=1, BrReady=1, BrDone=0.
  - Flags_In=1111 with Cond=0001 (BE) -> BrDone pulse 1 cycle later, BrTaken=1.
- subcc (op3=010100), Result=0, Carry=1, Overflow=0:
  - Flag outputs = N=0, Z=1, V=0, C=1.
  - Write_OutLow low for exactly 1 cycle, then AluReady low one more cycle (SETTLE), then high.
- andcc (op3=010001), Result=0x80000000, Carry=1, Overflow=1 -> flags N=1, Z=0, V=0, C=0, written once.
- Non-cc add (op3=000000) -> Write_OutLow stays 1, AluReady stays 1, state stays IDLE.
- Same-cycle cc op (Result=5) and branch BE with prior Flags_In Z=1:
  - BrReady=0 until SETTLE ends.
  - Branch is accepted with Flags_In=0000 -> BrTaken=0.
- Reset asserted during WRITE -> Write_OutLow returns high immediately (asynchronously); after release the block is in IDLE with all outputs at reset values.
- Sweep all 16 Cond values against Flags_In 0101 and 1010 -> BrTaken matches the condition function table.
